cpu_sequencer: RTL

//  Multi-cycle control FSM for the Jac1-8 core: fetches instructions, holds them in the IR that feeds
//  the combinational decoder, and gates the decoder's enables into single-cycle strobes.

---
 rtl/cpu_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//   Multi-cycle control FSM for the Jac1-8 core. It fetches an instruction over
//   a req/ack handshake, holds it in the IR that feeds the combinational
//   decoder, and turns the decoder's level enables into single-cycle strobes.
//   It also provides run/single-step debug control, a sticky instruction-fetch
//   timeout fault and a retired-instruction counter.
//
//   Instruction flow: HALT -> FETCH -> EXEC -> WB -> (FETCH | HALT)
//
// Ports
//   clk             in   clock, all state changes on the rising edge
//   reset_n         in   asynchronous active-low reset
//   run             in   level: 1 = free-run, 0 = stop after current instruction
//   step            in   pulse: execute exactly one instruction while halted
//   imem_req        out  instruction fetch request, held until imem_ack
//   imem_ack        in   imem_data valid this cycle
//   imem_data       in   fetched instruction word
//   instr_out       out  IR contents, drives the decoder
//   dec_wr_en       in   decoder register-file write enable
//   dec_cnt_wr_en   in   decoder PC load enable
//   dec_stat_wr_en  in   decoder status-register write enable
//   reg_wr_en       out  register-file write strobe (WB)
//   stat_wr_en      out  status-register write strobe (EXEC)
//   pc_wr_en        out  PC load strobe (WB)
//   pc_inc          out  PC increment strobe (WB)
//   halted          out  1 while in HALT
//   fault           out  sticky fetch-timeout flag, cleared only by reset
//   instr_count     out  retired instruction count, wraps
// -----------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int PROGRAM_DataWidth = 16,
    parameter int CntWidth          = 16,
    parameter int IMEM_TIMEOUT      = 15
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         run,
    input  logic                         step,
    output logic                         imem_req,
    input  logic                         imem_ack,
    input  logic [PROGRAM_DataWidth-1:0] imem_data,
    output logic [PROGRAM_DataWidth-1:0] instr_out,
    input  logic                         dec_wr_en,
    input  logic                         dec_cnt_wr_en,
    input  logic                         dec_stat_wr_en,
    output logic                         reg_wr_en,
    output logic                         stat_wr_en,
    output logic                         pc_wr_en,
    output logic                         pc_inc,
    output logic                         halted,
    output logic                         fault,
    output logic [CntWidth-1:0]          instr_count
);

    localparam int TW = $clog2(IMEM_TIMEOUT + 1);

    // One-hot encoding: every state-decoded output is a single flop bit, so
    // no output can glitch while the state register changes.
    typedef enum logic [3:0] {
        S_HALT  = 4'b0001,
        S_FETCH = 4'b0010,
        S_EXEC  = 4'b0100,
        S_WB    = 4'b1000
    } state_t;

    state_t                       state_q;
    logic [PROGRAM_DataWidth-1:0] ir_q;
    logic                         fault_q;
    logic [CntWidth-1:0]          count_q;
    logic [CntWidth-1:0]          count_d;
    logic [TW-1:0]                tmo_q;
    logic [TW-1:0]                tmo_d;
    logic                         single_q;

    assign count_d = count_q + 1'b1;
    assign tmo_d   = tmo_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_HALT;
            ir_q     <= '0;
            fault_q  <= 1'b0;
            count_q  <= '0;
            tmo_q    <= '0;
            single_q <= 1'b0;
        end else begin
            case (state_q)
                S_HALT: begin
                    tmo_q <= '0;
                    // A latched fault parks the sequencer until reset.
                    if (!fault_q) begin
                        if (run) begin
                            single_q <= 1'b0;
                            state_q  <= S_FETCH;
                        end else if (step) begin
                            single_q <= 1'b1;
                            state_q  <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    // Ack takes priority over a timeout expiring in the same cycle.
                    if (imem_ack) begin
                        ir_q    <= imem_data;
                        state_q <= S_EXEC;
                    end else if (tmo_d == TW'(IMEM_TIMEOUT)) begin
                        fault_q <= 1'b1;
                        state_q <= S_HALT;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_EXEC: begin
                    tmo_q   <= '0;
                    state_q <= S_WB;
                end
                S_WB: begin
                    tmo_q    <= '0;
                    count_q  <= count_d;
                    single_q <= 1'b0;
                    if (run && !single_q) begin
                        state_q <= S_FETCH;
                    end else begin
                        state_q <= S_HALT;
                    end
                end
                default: begin
                    state_q <= S_HALT;
                end
            endcase
        end
    end

    // Strobes are qualified by a single state flop, so they exist only in
    // their own state and vanish immediately when reset forces HALT.
    assign imem_req    = state_q[1];
    assign halted      = state_q[0];
    assign stat_wr_en  = state_q[2] & dec_stat_wr_en;
    assign reg_wr_en   = state_q[3] & dec_wr_en;
    assign pc_wr_en    = state_q[3] & dec_cnt_wr_en;
    assign pc_inc      = state_q[3] & ~dec_cnt_wr_en;
    assign instr_out   = ir_q;
    assign fault       = fault_q;
    assign instr_count = count_q;

endmodule
